// File: rtl/tiny_shader_spi_receiver.sv
// SPI mode-0 slave front end for the tiny shader: oversamples the SPI pins in the
// system clock domain, turns write transactions into instruction-memory strobes and
// returns a status byte on MISO.
module tiny_shader_spi_receiver #(
  parameter int NUM_INSTR   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         spi_sclk_i,
  input  logic                         spi_mosi_i,
  input  logic                         spi_cs_i,
  output logic                         spi_miso_o,
  input  logic [7:0]                   status_i,
  output logic                         instr_wr_o,
  output logic [$clog2(NUM_INSTR)-1:0] instr_addr_o,
  output logic [7:0]                   instr_data_o,
  output logic                         prog_done_o
);

  localparam int AW = $clog2(NUM_INSTR);

  typedef enum logic [2:0] {IDLE, CMD, WRITE, READ, IGNORE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
  logic [SYNC_STAGES:0]   vld_sync;
  logic                   sclk_prev, mosi_prev, cs_prev, armed;
  logic                   sclk_rise_q, sclk_fall_q, cs_rise_q, cs_fall_q;

  state_t                 state_q, state_d;
  logic [2:0]             bit_cnt;
  logic [6:0]             rx_shift;
  logic [7:0]             rx_byte;
  logic [7:0]             tx_shift;
  logic [AW-1:0]          ptr;
  logic                   wrote;
  logic                   byte_done, start, enter_write, enter_read, wr_fire;

  // Edge pulses are registered, so FSM actions land one clock after the pulse.
  // armed stays low after reset until CS is seen settled high, so a transfer that
  // was already running when reset released is ignored until CS toggles.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_sync   <= '0;
      mosi_sync   <= '0;
      cs_sync     <= '1;
      vld_sync    <= '0;
      sclk_prev   <= 1'b0;
      mosi_prev   <= 1'b0;
      cs_prev     <= 1'b1;
      armed       <= 1'b0;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      cs_rise_q   <= 1'b0;
      cs_fall_q   <= 1'b0;
    end else begin
      sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
      mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      cs_sync     <= {cs_sync[SYNC_STAGES-2:0], spi_cs_i};
      vld_sync    <= {vld_sync[SYNC_STAGES-1:0], 1'b1};
      sclk_prev   <= sclk_sync[SYNC_STAGES-1];
      mosi_prev   <= mosi_sync[SYNC_STAGES-1];
      cs_prev     <= cs_sync[SYNC_STAGES-1];
      armed       <= armed | (vld_sync[SYNC_STAGES] & cs_sync[SYNC_STAGES-1] & cs_prev);
      sclk_rise_q <= sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
      sclk_fall_q <= ~sclk_sync[SYNC_STAGES-1] & sclk_prev;
      cs_rise_q   <= cs_sync[SYNC_STAGES-1] & ~cs_prev;
      cs_fall_q   <= armed & ~cs_sync[SYNC_STAGES-1] & cs_prev;
    end
  end

  assign rx_byte   = {rx_shift, mosi_prev};
  assign byte_done = sclk_rise_q && (bit_cnt == 3'd7) && (state_q != IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_d     = state_q;
    start       = 1'b0;
    enter_write = 1'b0;
    enter_read  = 1'b0;
    wr_fire     = 1'b0;
    if (cs_rise_q) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (cs_fall_q) begin
          state_d = CMD;
          start   = 1'b1;
        end
        CMD: if (byte_done) begin
          if (rx_byte[7]) begin
            state_d     = WRITE;
            enter_write = 1'b1;
          end else if (rx_byte == 8'h40) begin
            state_d    = READ;
            enter_read = 1'b1;
          end else begin
            state_d = IGNORE;
          end
        end
        WRITE:   wr_fire = byte_done;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt      <= '0;
      rx_shift     <= '0;
      tx_shift     <= '0;
      ptr          <= '0;
      wrote        <= 1'b0;
      instr_wr_o   <= 1'b0;
      instr_addr_o <= '0;
      instr_data_o <= '0;
      prog_done_o  <= 1'b0;
    end else begin
      instr_wr_o  <= wr_fire;
      prog_done_o <= cs_rise_q & wrote;

      if (start) begin
        bit_cnt <= '0;
        wrote   <= 1'b0;
      end else if (sclk_rise_q && state_q != IDLE) begin
        rx_shift <= rx_byte[6:0];
        bit_cnt  <= bit_cnt + 3'd1;
      end

      if (enter_write) ptr <= rx_byte[AW-1:0];

      if (wr_fire) begin
        instr_addr_o <= ptr;
        instr_data_o <= rx_byte;
        ptr          <= ptr + AW'(1);
        wrote        <= 1'b1;
      end else if (cs_rise_q) begin
        wrote <= 1'b0;
      end

      // The fall that closes each byte (bit_cnt back at 0) reloads the status, so
      // the master sees the status MSB first on every byte.
      if (enter_read) begin
        tx_shift <= status_i;
      end else if (state_q == READ && sclk_fall_q) begin
        tx_shift <= (bit_cnt == 3'd0) ? status_i : {tx_shift[6:0], 1'b0};
      end
    end
  end

  assign spi_miso_o = (state_q == READ) & tx_shift[7];

endmodule

// File: tb/tb_tiny_shader_spi_receiver.sv
// Directed self-checking bench for tiny_shader_spi_receiver: writes, wrap, partial
// byte, status read, invalid command and reset in the middle of a transfer.
module tb_tiny_shader_spi_receiver;

  localparam int NI = 16;
  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk, mosi, cs, miso;
  logic [7:0] status;
  logic       wr;
  logic [3:0] addr;
  logic [7:0] data;
  logic       done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  tiny_shader_spi_receiver #(.NUM_INSTR(NI), .SYNC_STAGES(SS)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .spi_sclk_i  (sclk),
    .spi_mosi_i  (mosi),
    .spi_cs_i    (cs),
    .spi_miso_o  (miso),
    .status_i    (status),
    .instr_wr_o  (wr),
    .instr_addr_o(addr),
    .instr_data_o(data),
    .prog_done_o (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling clock edge.
  int         wr_count   = 0;
  int         done_count = 0;
  int         miso_hi    = 0;
  int         b2b        = 0;
  logic       wr_last    = 1'b0;
  logic [3:0] wr_addr[32];
  logic [7:0] wr_data[32];
  int         wr_cyc[32];

  always @(negedge clk) begin
    if (wr === 1'b1) begin
      if (wr_count < 32) begin
        wr_addr[wr_count] = addr;
        wr_data[wr_count] = data;
        wr_cyc[wr_count]  = cyc;
      end
      wr_count++;
      if (wr_last) b2b++;
    end
    wr_last = (wr === 1'b1);
    if (done === 1'b1) done_count++;
    if (miso === 1'b1) miso_hi++;
  end

  int          last_rise;
  logic [15:0] miso_bits;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b);
    mosi = b;
    tick(8);
    miso_bits = {miso_bits[14:0], miso};
    sclk      = 1'b1;
    last_rise = cyc;
    tick(8);
    sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  int wb, db, mb, lat;

  initial begin
    // Reset with random pins
    rst    = 1'b1;
    sclk   = 1'($urandom);
    mosi   = 1'($urandom);
    cs     = 1'($urandom);
    status = 8'($urandom);
    tick(5);
    check("rst_wr",   32'(wr),   32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    cs   = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    tick(2);
    rst = 1'b0;
    wb = wr_count; db = done_count; mb = miso_hi;
    tick(100);
    check("idle_no_wr",   32'(wr_count - wb),   32'd0);
    check("idle_no_done", 32'(done_count - db), 32'd0);
    check("idle_no_miso", 32'(miso_hi - mb),    32'd0);

    // Program write: 0x82, 0xA5, 0x3C
    wb = wr_count; db = done_count;
    cs = 1'b0;
    tick(8);
    spi_byte(8'h82);
    spi_byte(8'hA5);
    lat = last_rise;
    spi_byte(8'h3C);
    tick(8);
    cs = 1'b1;
    tick(20);
    check("prog_wr_count", 32'(wr_count - wb),       32'd2);
    check("prog_addr0",    32'(wr_addr[wb]),         32'd2);
    check("prog_data0",    32'(wr_data[wb]),         32'hA5);
    check("prog_latency",  32'(wr_cyc[wb] - lat),    32'(SS + 2));
    check("prog_addr1",    32'(wr_addr[wb + 1]),     32'd3);
    check("prog_data1",    32'(wr_data[wb + 1]),     32'h3C);
    check("prog_done",     32'(done_count - db),     32'd1);
    check("prog_hold_addr", 32'(addr),               32'd3);
    check("prog_hold_data", 32'(data),               32'h3C);

    // Wrap and partial byte
    wb = wr_count; db = done_count;
    cs = 1'b0;
    tick(8);
    spi_byte(8'h8F);
    spi_byte(8'h11);
    spi_byte(8'h22);
    spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1); spi_bit(1'b1);
    tick(8);
    cs = 1'b1;
    tick(20);
    check("wrap_wr_count", 32'(wr_count - wb),   32'd2);
    check("wrap_addr0",    32'(wr_addr[wb]),     32'd15);
    check("wrap_data0",    32'(wr_data[wb]),     32'h11);
    check("wrap_addr1",    32'(wr_addr[wb + 1]), 32'd0);
    check("wrap_data1",    32'(wr_data[wb + 1]), 32'h22);
    check("wrap_done",     32'(done_count - db), 32'd1);

    // Status read
    wb = wr_count; db = done_count;
    status = 8'hC3;
    cs = 1'b0;
    tick(8);
    spi_byte(8'h40);
    spi_byte(8'h00);
    check("read_byte0", 32'(miso_bits[7:0]), 32'hC3);
    spi_byte(8'h00);
    check("read_byte1", 32'(miso_bits[7:0]), 32'hC3);
    tick(8);
    cs = 1'b1;
    tick(20);
    check("read_miso_after", 32'(miso),             32'd0);
    check("read_no_wr",      32'(wr_count - wb),    32'd0);
    check("read_no_done",    32'(done_count - db),  32'd0);

    // Invalid command
    wb = wr_count; db = done_count; mb = miso_hi;
    cs = 1'b0;
    tick(8);
    spi_byte(8'h05);
    spi_byte(8'hFF);
    tick(8);
    cs = 1'b1;
    tick(20);
    check("inv_no_wr",   32'(wr_count - wb),   32'd0);
    check("inv_no_done", 32'(done_count - db), 32'd0);
    check("inv_miso",    32'(miso_hi - mb),    32'd0);

    // Reset in the middle of a write transaction
    wb = wr_count; db = done_count;
    cs = 1'b0;
    tick(8);
    spi_byte(8'h81);
    spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1);
    rst = 1'b1;
    tick(3);
    check("mid_rst_addr", 32'(addr), 32'd0);
    check("mid_rst_data", 32'(data), 32'd0);
    rst = 1'b0;
    spi_bit(1'b0); spi_bit(1'b0); spi_bit(1'b1); spi_bit(1'b1); spi_bit(1'b0);
    tick(8);
    cs = 1'b1;
    tick(20);
    check("mid_no_wr",   32'(wr_count - wb),   32'd0);
    check("mid_no_done", 32'(done_count - db), 32'd0);

    wb = wr_count; db = done_count;
    cs = 1'b0;
    tick(8);
    spi_byte(8'h80);
    spi_byte(8'h77);
    tick(8);
    cs = 1'b1;
    tick(20);
    check("post_wr_count", 32'(wr_count - wb),   32'd1);
    check("post_addr",     32'(wr_addr[wb]),     32'd0);
    check("post_data",     32'(wr_data[wb]),     32'h77);
    check("post_done",     32'(done_count - db), 32'd1);

    check("strobe_spacing", 32'(b2b), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
